// File: rtl/asm_unit_pkg.sv
// rtl/asm_unit_pkg.sv - default operand and accumulator widths for the sign-activation unit
package asm_unit_pkg;

  localparam int asm_default_img_width    = 16;
  localparam int asm_default_bn_width     = 16;
  localparam int asm_default_result_width = 22;

endpackage

// File: rtl/asm_addsub.sv
// rtl/asm_addsub.sv - wrapping add/subtract of a sign-extended operand, selected by a binary weight
module asm_addsub #(
  parameter int in_width  = 16,
  parameter int out_width = 22
) (
  input  logic [out_width-1:0] acc,
  input  logic [in_width-1:0]  operand,
  input  logic                 add,
  output logic [out_width-1:0] result
);

  logic [out_width-1:0] operand_ext;

  // Widen before negating so the most negative operand flips to its exact positive value.
  assign operand_ext = {{(out_width - in_width){operand[in_width-1]}}, operand};
  assign result      = add ? (acc + operand_ext) : (acc - operand_ext);

endmodule

// File: rtl/asm_unit.sv
// rtl/asm_unit.sv - binary-weight accumulate, bias add and sign activation
module asm_unit
  import asm_unit_pkg::*;
#(
  parameter int img_width    = asm_default_img_width,
  parameter int bn_width     = asm_default_bn_width,
  parameter int result_width = asm_default_result_width
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 asm_send,
  input  logic                 asm_reception,
  input  logic                 calculate_en,
  input  logic                 data_weights,
  input  logic [img_width-1:0] data_pix,
  input  logic [bn_width-1:0]  data_bn,
  output logic                 data_out
);

  logic signed [result_width-1:0] acc;
  logic signed [result_width-1:0] bias;
  logic        [result_width-1:0] acc_next;
  logic        [result_width:0]   sum;

  asm_addsub #(
    .in_width  (img_width),
    .out_width (result_width)
  ) u_addsub (
    .acc     (acc),
    .operand (data_pix),
    .add     (data_weights),
    .result  (acc_next)
  );

  // One extra bit keeps the sign of acc + bias correct for any pair of inputs.
  assign sum = {acc[result_width-1], acc} + {bias[result_width-1], bias};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      bias     <= '0;
      data_out <= 1'b0;
    end else if (asm_reception) begin
      bias <= {{(result_width - bn_width){data_bn[bn_width-1]}}, data_bn};
      acc  <= '0;
    end else if (asm_send) begin
      data_out <= ~sum[result_width];
      acc      <= '0;
    end else if (calculate_en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: tb/tb_asm_unit.sv
// tb/tb_asm_unit.sv - directed and randomized checks of asm_unit against an integer reference model
module tb_asm_unit;

  localparam int IW = 16;
  localparam int BW = 16;
  localparam int RW = 22;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          asm_send = 1'b0;
  logic          asm_reception = 1'b0;
  logic          calculate_en = 1'b0;
  logic          data_weights = 1'b0;
  logic [IW-1:0] data_pix = '0;
  logic [BW-1:0] data_bn = '0;
  logic          data_out;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint m_acc = 0;
  longint m_bias = 0;
  logic   m_out = 1'b0;

  always #5 clk = ~clk;

  asm_unit #(
    .img_width    (IW),
    .bn_width     (BW),
    .result_width (RW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .asm_send      (asm_send),
    .asm_reception (asm_reception),
    .calculate_en  (calculate_en),
    .data_weights  (data_weights),
    .data_pix      (data_pix),
    .data_bn       (data_bn),
    .data_out      (data_out)
  );

  // Reduce an unbounded sum to the signed value of a RW-bit register.
  function automatic longint wrap(input longint v);
    longint m;
    longint r;
    m = longint'(1) << RW;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_acc(input string tag, input longint exp);
    longint obs;
    obs = longint'($signed(dut.acc));
    n_cmp++;
    assert (obs === wrap(exp)) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, wrap(exp));
    end
  endtask

  task automatic step(input logic r, input logic rec, input logic snd, input logic cal,
                      input logic w, input logic [IW-1:0] pix, input logic [BW-1:0] bn,
                      input string tag);
    longint p;
    @(negedge clk);
    rst = r; asm_reception = rec; asm_send = snd; calculate_en = cal;
    data_weights = w; data_pix = pix; data_bn = bn;
    @(posedge clk);
    p = longint'($signed(pix));
    if (r) begin
      m_acc = 0; m_bias = 0; m_out = 1'b0;
    end else if (rec) begin
      m_bias = longint'($signed(bn)); m_acc = 0;
    end else if (snd) begin
      m_out = (wrap(m_acc) + m_bias >= 0); m_acc = 0;
    end else if (cal) begin
      m_acc = w ? m_acc + p : m_acc - p;
    end
    #1;
    check_bit({tag, "_out"}, data_out, m_out);
    check_acc({tag, "_acc"}, m_acc);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, '0, '0, tag);
  endtask

  initial begin
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, '0, '0, "reset");
    check_bit("reset_const", data_out, 1'b0);
    step(0, 0, 1, 0, 0, '0, '0, "send_after_reset");
    check_bit("zero_sum_const", data_out, 1'b1);

    step(0, 1, 0, 0, 0, '0, 16'd5, "pos_rec");
    step(0, 0, 0, 1, 1, 16'd10, '0, "pos_c1");
    step(0, 0, 0, 1, 1, 16'd10, '0, "pos_c2");
    step(0, 0, 0, 1, 0, 16'd10, '0, "pos_c3");
    check_acc("pos_acc_const", 10);
    step(0, 0, 1, 0, 0, '0, '0, "pos_send");
    check_bit("pos_const", data_out, 1'b1);

    step(0, 1, 0, 0, 0, '0, 16'hFF9C, "neg_rec");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 16'd20, '0, "neg_calc");
    step(0, 0, 1, 0, 0, '0, '0, "neg_send");
    check_bit("neg_const", data_out, 1'b0);

    step(0, 1, 0, 0, 0, '0, 16'hFFE2, "zero_rec");
    step(0, 0, 0, 1, 1, 16'd30, '0, "zero_calc");
    step(0, 0, 1, 0, 0, '0, '0, "zero_send");
    check_bit("zero_const", data_out, 1'b1);
    step(0, 0, 0, 1, 0, 16'h8000, '0, "minneg_calc");
    check_acc("minneg_acc_const", 32768);
    step(0, 0, 1, 0, 0, '0, '0, "minneg_send");
    check_bit("minneg_const", data_out, 1'b1);

    step(0, 1, 0, 0, 0, '0, 16'hFFEC, "sim_rec");
    step(0, 0, 0, 1, 1, 16'd10, '0, "sim_calc");
    step(0, 0, 1, 1, 1, 16'd50, '0, "sim_send_calc");
    check_bit("sim_send_const", data_out, 1'b0);
    check_acc("sim_acc_const", 0);
    step(0, 1, 1, 0, 0, '0, 16'd7, "sim_rec_send");
    check_bit("sim_rec_send_const", data_out, 1'b0);
    step(0, 0, 1, 0, 0, '0, '0, "sim_send_bias7");
    check_bit("sim_bias7_const", data_out, 1'b1);

    step(0, 1, 0, 0, 0, '0, '0, "range_rec");
    for (int i = 0; i < 64; i++) step(0, 0, 0, 1, 1, 16'h7FFF, '0, "range_calc");
    check_acc("range_acc_const", 2097088);
    step(0, 0, 1, 0, 0, '0, '0, "range_send");
    check_bit("range_const", data_out, 1'b1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 16'h7FFF, '0, "range_calc2");
    step(1, 0, 0, 0, 0, '0, '0, "range_rst");
    check_bit("range_rst_const", data_out, 1'b0);
    check_acc("range_rst_acc_const", 0);
    idle("range_idle");
    step(0, 0, 1, 0, 0, '0, '0, "range_send_after_rst");
    check_bit("range_send_after_rst_const", data_out, 1'b1);

    for (int i = 0; i < 600; i++) begin
      logic [7:0] sel;
      sel = 8'($urandom_range(0, 255));
      step(sel < 2, sel >= 2 && sel < 14, sel >= 14 && sel < 40, sel >= 30,
           1'($urandom), IW'($urandom), BW'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
